// File: rtl/axis_xbar_arb.sv
// Packet-level round-robin arbiter driving the one-hot crossbar select; grant registered one cycle after request.
// Holds each grant until the tlast beat. Never throttles the stream. A stalled grant raises a sticky flag.
module axis_xbar_arb #(
  parameter int CHANNEL      = 2,
  parameter int STALL_CYCLES = 1024,
  localparam int ID_W        = ($clog2(CHANNEL) < 1) ? 1 : $clog2(CHANNEL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CHANNEL-1:0] req,
  input  logic [CHANNEL-1:0] enable,
  input  logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  input  logic               m_axis_tlast,
  output logic [CHANNEL-1:0] switch,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic [31:0]        pkt_cnt,
  output logic               stall_err,
  input  logic               err_clr
);

  localparam int CNT_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]   STALL_MAX = CNT_W'(STALL_CYCLES);
  localparam logic [ID_W-1:0]    LAST_RST  = ID_W'(CHANNEL - 1);
  localparam logic [CHANNEL-1:0] ONE       = CHANNEL'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CHANNEL-1:0] elig;
  logic               found;
  logic [ID_W-1:0]    win;
  logic               beat;
  logic               eop;
  logic [CNT_W-1:0]   stall_cnt;

  assign beat = m_axis_tvalid & m_axis_tready;
  assign eop  = beat & m_axis_tlast;
  assign busy = (state == BUSY);

  // grant_id doubles as the round-robin pointer: search starts just after it.
  always_comb begin
    int idx;
    idx   = 0;
    elig  = req & enable;
    found = 1'b0;
    win   = grant_id;
    for (int i = 1; i <= CHANNEL; i++) begin
      idx = (int'(grant_id) + i) % CHANNEL;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      switch    <= '0;
      grant_id  <= LAST_RST;
      pkt_cnt   <= '0;
      stall_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (eop)
        pkt_cnt <= pkt_cnt + 32'd1;

      if (STALL_CYCLES != 0 && state == BUSY && stall_cnt == STALL_MAX)
        stall_err <= 1'b1;
      else if (err_clr)
        stall_err <= 1'b0;

      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (found) begin
            switch   <= ONE << win;
            grant_id <= win;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (eop) begin
            stall_cnt <= '0;
            if (found) begin
              switch   <= ONE << win;
              grant_id <= win;
            end else begin
              switch <= '0;
              state  <= IDLE;
            end
          end else if (beat) begin
            stall_cnt <= '0;
          end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_xbar_arb.sv
// Scoreboard bench for axis_xbar_arb: expected grants queued with stimulus, popped on each new grant.
module tb_axis_xbar_arb;

  localparam int CH = 4;

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] req;
  logic [CH-1:0] enable;
  logic          tvalid, tready, tlast;
  logic          err_clr;
  logic [CH-1:0] switch;
  logic [1:0]    grant_id;
  logic          busy;
  logic [31:0]   pkt_cnt;
  logic          stall_err;

  int vecs = 0;
  int errs = 0;
  int exp_q[$];
  int exp_pkt = 0;

  axis_xbar_arb #(.CHANNEL(CH), .STALL_CYCLES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .enable        (enable),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .switch        (switch),
    .grant_id      (grant_id),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt),
    .stall_err     (stall_err),
    .err_clr       (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    exp_pkt = 0;
  endtask

  // Drives a packet of back-to-back beats; req takes req_last on the tlast beat.
  task automatic send_pkt(input int beats, input logic [CH-1:0] req_last, input logic [CH-1:0] exp_sw);
    for (int b = 0; b < beats; b++) begin
      tvalid = 1'b1;
      tready = 1'b1;
      tlast  = (b == beats - 1);
      if (b == beats - 1) req = req_last;
      chk("hold_busy", busy, 1);
      chk("hold_switch", switch, exp_sw);
      tick();
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    exp_pkt++;
  endtask

  // Grant monitor: a new grant is busy rising, or busy held across an eop.
  initial begin
    logic prev_busy, prev_eop;
    int e;
    prev_busy = 1'b0;
    prev_eop  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_busy = 1'b0;
        prev_eop  = 1'b0;
      end else begin
        if (busy && (!prev_busy || prev_eop)) begin
          chk("grant_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("grant_id", grant_id, e);
            chk("grant_switch", switch, 32'(1) << e);
          end
        end
        prev_busy = busy;
        prev_eop  = busy && tvalid && tready && tlast;
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; enable = '1;
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; err_clr = 1'b0;

    // Reset then idle
    tick();
    chk("rst_switch", switch, 0);
    chk("rst_grant_id", grant_id, CH - 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_switch", switch, 0);
      chk("idle_busy", busy, 0);
      chk("idle_pkt_cnt", pkt_cnt, 0);
      chk("idle_grant_id", grant_id, CH - 1);
    end

    // Single requester, 3-beat packet
    req = 4'b0010;
    exp_q.push_back(1);
    tick();
    chk("single_switch", switch, 4'b0010);
    chk("single_busy", busy, 1);
    send_pkt(3, 4'b0000, 4'b0010);
    chk("single_release_switch", switch, 0);
    chk("single_release_busy", busy, 0);
    chk("single_pkt_cnt", pkt_cnt, exp_pkt);

    // Round robin, all requesting, 2-beat packets
    do_reset();
    foreach (exp_q[i]) chk("q_empty_before_rr", 1, 0);
    exp_q = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    tick();
    for (int p = 0; p < 5; p++)
      send_pkt(2, (p == 4) ? 4'b0000 : 4'b1111, 4'(1 << (p % 4)));
    chk("rr_idle_busy", busy, 0);
    chk("rr_pkt_cnt", pkt_cnt, 5);

    // Mask and hold: drop req/enable of the granted channel mid-packet
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    exp_q.push_back(2);
    req = 4'b0010;
    tick();
    tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
    chk("mask_switch_b1", switch, 4'b0010);
    tick();
    req = 4'b0000; enable = 4'b1101;
    chk("mask_switch_b2", switch, 4'b0010);
    tick();
    tlast = 1'b1; req = 4'b1111;
    chk("mask_switch_b3", switch, 4'b0010);
    chk("mask_busy_b3", busy, 1);
    tick();
    tlast = 1'b0; tvalid = 1'b0;
    exp_pkt++;
    send_pkt(1, 4'b1111, 4'b0100);
    send_pkt(1, 4'b1111, 4'b1000);
    send_pkt(1, 4'b1111, 4'b0001);
    send_pkt(1, 4'b0000, 4'b0100);
    enable = 4'b1111;
    chk("mask_idle_busy", busy, 0);
    chk("mask_pkt_cnt", pkt_cnt, exp_pkt);

    // Stall detection with ready held low
    req = 4'b0001;
    exp_q.push_back(0);
    tick();
    tvalid = 1'b1; tready = 1'b0; tlast = 1'b0; req = '0;
    repeat (8) tick();
    chk("stall_early", stall_err, 0);
    tick();
    chk("stall_set", stall_err, 1);
    chk("stall_switch_kept", switch, 4'b0001);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("stall_set_beats_clr", stall_err, 1);
    tready = 1'b1;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("stall_cleared", stall_err, 0);
    send_pkt(1, 4'b0000, 4'b0001);
    chk("stall_idle_busy", busy, 0);
    chk("stall_pkt_cnt", pkt_cnt, exp_pkt);

    // Reset asserted mid-packet
    req = 4'b0110;
    exp_q.push_back(1);
    tick();
    for (int b = 0; b < 2; b++) begin
      tvalid = 1'b1; tready = 1'b1; tlast = 1'b0;
      chk("rstmid_switch", switch, 4'b0010);
      tick();
    end
    rst_n = 1'b0;
    tvalid = 1'b0;
    #1;
    chk("rstmid_switch_now", switch, 0);
    chk("rstmid_busy_now", busy, 0);
    chk("rstmid_grant_id", grant_id, CH - 1);
    chk("rstmid_pkt_cnt", pkt_cnt, 0);
    exp_pkt = 0;
    tick();
    tick();
    exp_q.push_back(1);
    rst_n = 1'b1;
    tick();
    chk("rstmid_regrant", switch, 4'b0010);
    send_pkt(1, 4'b0000, 4'b0010);
    chk("rstmid_idle_busy", busy, 0);
    chk("rstmid_pkt_after", pkt_cnt, exp_pkt);

    tick();
    tick();
    chk("grants_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/axis_xbar_arb.md
# axis_xbar_arb

Packet-level round-robin arbiter that drives the one-hot `switch` select of the AXI-Stream crossbar in the shell datapath. It watches per-channel source `tvalid` and the crossbar's master-side handshake, and grants one input channel at a time. Each grant is held from the first beat to the `tlast` beat of a packet, so packets from different sources never interleave. It also keeps a completed-packet count and raises a sticky stall flag when a granted channel stops making progress.

## Interface
- `CHANNEL`, 2 — number of crossbar input channels; ≥ 2.
- `STALL_CYCLES`, 1024 — number of consecutive BUSY cycles without a beat before `stall_err` sets; 0 disables stall detection.
- `ID_W`, derived = max(1, $clog2(CHANNEL)) — width of `grant_id`.

Ports:
- `clk` in 1 — single clock; all logic is on its rising edge.
- `rst_n` in 1 — reset, asynchronous assert, active-low.
- `req` in CHANNEL — per-channel source `s_axis_tvalid`, used as the request.
- `enable` in CHANNEL — channel mask; a 0 bit makes that channel ineligible for new grants.
- `m_axis_tvalid` in 1 — crossbar output valid (monitored).
- `m_axis_tready` in 1 — downstream ready (monitored).
- `m_axis_tlast` in 1 — crossbar output last (monitored).
- `switch` out CHANNEL — registered one-hot grant to the crossbar; all zeros when idle.
- `grant_id` out ID_W — binary index of the granted channel; holds the last grant while idle.
- `busy` out 1 — a packet is in progress (state BUSY).
- `pkt_cnt` out 32 — number of packets completed, wrapping.
- `stall_err` out 1 — sticky stall flag.
- `err_clr` in 1 — clears `stall_err`.

## Operation
- A beat is a cycle with `m_axis_tvalid & m_axis_tready`. End of packet (eop) is a beat with `m_axis_tlast`.
- Eligible set: `req & enable`.
- State machine has two states, IDLE and BUSY.
  - IDLE: `switch`=0. If the eligible set is non-zero, select a winner, load `switch` and `grant_id`, and go to BUSY.
  - BUSY: `switch` is held constant. On eop, re-arbitrate in the same cycle. If the eligible set is non-zero, load the new winner and stay in BUSY. Otherwise clear `switch` and go to IDLE.
- Round-robin pointer `last`:
  - Search order is `last+1, last+2, …` modulo CHANNEL; the first eligible channel wins.
  - `last` updates to the winner on every grant.
  - Reset value of `last` is CHANNEL-1, so channel 0 has top priority after reset.
- A lone requester is re-granted back-to-back; `switch` does not change value.
- `req` or `enable` falling while BUSY has no effect; the grant is released only by eop.
- A beat with tlast=0 does nothing except feed the stall counter.
- Stall counter:
  - In BUSY it increments every cycle without a beat. It resets on a beat, on a new grant, and in IDLE.
  - When it reaches STALL_CYCLES (if non-zero), `stall_err` sets. The counter saturates at that value.
  - The grant is not revoked on stall.
- `err_clr` clears `stall_err`. If set and clear occur in the same cycle, set wins.
- `pkt_cnt` increments by 1 on each eop and wraps from 2^32-1 to 0.
- Reset values: `switch`=0, `grant_id`=CHANNEL-1, `busy`=0, `pkt_cnt`=0, `stall_err`=0; state is IDLE; stall counter is 0.
- Reset asserted mid-packet returns every output to its reset value immediately; any partial packet is abandoned.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Grant latency from IDLE: eligible request at cycle n → `switch`, `grant_id` and `busy` valid at n+1. The first beat can occur at n+1.
- Packet-to-packet: eop at cycle k with another eligible requester → new `switch` at k+1, giving zero bubble cycles.
- Eop at k with no eligible requester → `switch`=0 and `busy`=0 at k+1.
- `pkt_cnt` updates at k+1 for an eop at k.
- `stall_err` rises in the cycle after the counter reaches STALL_CYCLES. With grant at n and no beats, `stall_err`=1 at n+STALL_CYCLES+1.

## Test plan
- Reset then idle: `req`=0 for 10 cycles → `switch`=0, `busy`=0, `pkt_cnt`=0, `grant_id`=CHANNEL-1 throughout.
- Single channel, CHANNEL=2: `req`=2'b10, 3-beat packet, ready held high → `switch`=2'b10 one cycle after `req`, held for all 3 beats. `switch`=0 the cycle after tlast; `pkt_cnt`=1.
- Round-robin, CHANNEL=4: all four channels always requesting, 2-beat packets → grant order 0,1,2,3,0 with no idle cycles between packets; `pkt_cnt`=5 after 10 beats.
- Mask and hold: channel 1 granted, then `enable[1]` and `req[1]` dropped mid-packet → `switch` stays 4'b0010 until tlast. Afterwards channel 1 is skipped while `enable[1]`=0.
- Stall, STALL_CYCLES=8: grant channel 0 with `m_axis_tready`=0 → `stall_err`=1 at grant+9 and `switch` still granted. Assert `err_clr` after restoring ready → `stall_err`=0 next cycle. Hold ready low and pulse `err_clr` when the counter saturates → `stall_err` remains 1.
- Reset mid-packet: deassert `rst_n` after beat 2 of a 5-beat packet → `switch`=0 and `busy`=0 immediately. After release, the pending request is re-granted starting from channel 0 priority.
